// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and widths for the memory reservation station and AGU
package mem_pkg;

    localparam int MEM_DEPTH = 8;
    localparam int MEM_PC_W  = 12;
    localparam int MEM_TAG_W = 6;
    localparam int MEM_ROB_W = 4;
    localparam int MEM_AGE_W = $clog2(MEM_DEPTH);

    typedef enum logic {
        OP_STORE = 1'b0,
        OP_LOAD  = 1'b1
    } mem_op_t;

    typedef struct packed {
        logic                 valid;
        mem_op_t              op;
        logic                 byte_acc;
        logic [MEM_PC_W-1:0]  pc;
        logic [MEM_TAG_W-1:0] s1_tag;
        logic                 s1_rdy;
        logic [31:0]          s1_val;
        logic [MEM_TAG_W-1:0] s2_tag;
        logic                 s2_rdy;
        logic [31:0]          s2_val;
        logic [11:0]          imm;
        logic [MEM_TAG_W-1:0] rd;
        logic [MEM_ROB_W-1:0] rob;
        logic [MEM_AGE_W-1:0] age;
    } rs_entry_t;

    // Field set mirrors the LSQ's mem_res/mem_info payload
    typedef struct packed {
        logic [31:0]          addr;
        logic [31:0]          data;
        logic [MEM_PC_W-1:0]  pc;
        logic                 load;
        logic                 byte_acc;
        logic [MEM_TAG_W-1:0] rd;
        logic [MEM_ROB_W-1:0] rob;
    } agu_res_t;

    function automatic logic [31:0] agu_ea(input logic [31:0] base, input logic [11:0] imm);
        return base + {{20{imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/mem_agu_pick.sv
// rtl/mem_agu_pick.sv - oldest-ready selector: highest age wins, ties go to the lowest index
module mem_agu_pick #(
    parameter int N     = 8,
    parameter int AGE_W = 3,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]            eligible,
    input  logic [N-1:0][AGE_W-1:0] age,
    output logic [N-1:0]            grant,
    output logic [IDX_W-1:0]        idx,
    output logic                    any
);

    logic [AGE_W-1:0] best_age;

    always_comb begin
        grant    = '0;
        idx      = '0;
        any      = 1'b0;
        best_age = '0;
        // Strict compare keeps the earlier (lower) index on equal ages
        for (int i = 0; i < N; i++) begin
            if (eligible[i] && (!any || age[i] > best_age)) begin
                any      = 1'b1;
                best_age = age[i];
                idx      = IDX_W'(i);
            end
        end
        if (any) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_agu_rs.sv
// rtl/mem_agu_rs.sv - memory reservation station with CDB wakeup and registered address generation
module mem_agu_rs
    import mem_pkg::*;
#(
    parameter int DEPTH = MEM_DEPTH,
    parameter int PC_W  = MEM_PC_W,
    parameter int TAG_W = MEM_TAG_W,
    parameter int ROB_W = MEM_ROB_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             alloc_valid,
    output logic             alloc_ready,
    input  logic [PC_W-1:0]  alloc_pc,
    input  logic             alloc_load,
    input  logic             alloc_byte,
    input  logic [TAG_W-1:0] alloc_s1_tag,
    input  logic             alloc_s1_rdy,
    input  logic [31:0]      alloc_s1_val,
    input  logic [TAG_W-1:0] alloc_s2_tag,
    input  logic             alloc_s2_rdy,
    input  logic [31:0]      alloc_s2_val,
    input  logic [11:0]      alloc_imm,
    input  logic [TAG_W-1:0] alloc_rd,
    input  logic [ROB_W-1:0] alloc_rob,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    output logic             agu_valid,
    output logic [31:0]      agu_addr,
    output logic [31:0]      agu_data,
    output logic [PC_W-1:0]  agu_pc,
    output logic             agu_load,
    output logic             agu_byte,
    output logic [TAG_W-1:0] agu_rd,
    output logic [ROB_W-1:0] agu_rob
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [MEM_AGE_W-1:0] AGE_MAX = MEM_AGE_W'(DEPTH - 1);

    rs_entry_t rs_q [DEPTH];
    rs_entry_t rs_d [DEPTH];
    rs_entry_t new_e;
    rs_entry_t iss_e;
    agu_res_t  res_q;
    logic      agu_valid_q;

    logic [DEPTH-1:0]                valid_vec;
    logic [DEPTH-1:0]                elig;
    logic [DEPTH-1:0]                gnt;
    logic [DEPTH-1:0][MEM_AGE_W-1:0] age_vec;
    logic [IDX_W-1:0]                free_idx;
    logic [IDX_W-1:0]                pick_idx;
    logic                            pick_any;
    logic                            cdb_live;
    logic                            do_alloc;
    logic                            do_issue;

    always_comb begin
        valid_vec = '0;
        elig      = '0;
        age_vec   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i] = rs_q[i].valid;
            age_vec[i]   = rs_q[i].age;
            elig[i]      = rs_q[i].valid && rs_q[i].s1_rdy &&
                           (rs_q[i].op == OP_LOAD || rs_q[i].s2_rdy);
        end
    end

    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!rs_q[i].valid) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    mem_agu_pick #(
        .N     (DEPTH),
        .AGE_W (MEM_AGE_W),
        .IDX_W (IDX_W)
    ) u_pick (
        .eligible (elig),
        .age      (age_vec),
        .grant    (gnt),
        .idx      (pick_idx),
        .any      (pick_any)
    );

    // Slots freed by this cycle's issue only become visible next cycle
    assign alloc_ready = ~&valid_vec;
    assign cdb_live    = cdb_valid && (cdb_tag != '0);
    assign do_alloc    = alloc_valid && alloc_ready && !flush;
    assign do_issue    = pick_any && !flush;
    assign iss_e       = rs_q[pick_idx];

    always_comb begin
        new_e          = '0;
        new_e.valid    = 1'b1;
        new_e.op       = alloc_load ? OP_LOAD : OP_STORE;
        new_e.byte_acc = alloc_byte;
        new_e.pc       = alloc_pc;
        new_e.s1_tag   = alloc_s1_tag;
        new_e.s1_rdy   = alloc_s1_rdy;
        new_e.s1_val   = alloc_s1_val;
        new_e.s2_tag   = alloc_s2_tag;
        new_e.s2_rdy   = alloc_s2_rdy;
        new_e.s2_val   = alloc_s2_val;
        new_e.imm      = alloc_imm;
        new_e.rd       = alloc_rd;
        new_e.rob      = alloc_rob;
        if (cdb_live && !alloc_s1_rdy && alloc_s1_tag == cdb_tag) begin
            new_e.s1_rdy = 1'b1;
            new_e.s1_val = cdb_data;
        end
        if (cdb_live && !alloc_s2_rdy && alloc_s2_tag == cdb_tag) begin
            new_e.s2_rdy = 1'b1;
            new_e.s2_val = cdb_data;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rs_d[i] = rs_q[i];
            if (rs_q[i].valid) begin
                if (cdb_live && !rs_q[i].s1_rdy && rs_q[i].s1_tag == cdb_tag) begin
                    rs_d[i].s1_rdy = 1'b1;
                    rs_d[i].s1_val = cdb_data;
                end
                if (cdb_live && !rs_q[i].s2_rdy && rs_q[i].s2_tag == cdb_tag) begin
                    rs_d[i].s2_rdy = 1'b1;
                    rs_d[i].s2_val = cdb_data;
                end
                if (do_alloc && rs_q[i].age != AGE_MAX) begin
                    rs_d[i].age = rs_q[i].age + 1'b1;
                end
            end
            if (do_issue && gnt[i]) begin
                rs_d[i].valid = 1'b0;
            end
            if (do_alloc && free_idx == IDX_W'(i)) begin
                rs_d[i] = new_e;
            end
            if (flush) begin
                rs_d[i].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                rs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                rs_q[i] <= rs_d[i];
            end
        end
    end

    // Payload fields hold between pulses; only agu_valid drops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            agu_valid_q <= 1'b0;
            res_q       <= '0;
        end else if (do_issue) begin
            agu_valid_q    <= 1'b1;
            res_q.addr     <= agu_ea(iss_e.s1_val, iss_e.imm);
            res_q.data     <= (iss_e.op == OP_LOAD) ? 32'd0 : iss_e.s2_val;
            res_q.pc       <= iss_e.pc;
            res_q.load     <= (iss_e.op == OP_LOAD);
            res_q.byte_acc <= iss_e.byte_acc;
            res_q.rd       <= iss_e.rd;
            res_q.rob      <= iss_e.rob;
        end else begin
            agu_valid_q <= 1'b0;
        end
    end

    assign agu_valid = agu_valid_q;
    assign agu_addr  = res_q.addr;
    assign agu_data  = res_q.data;
    assign agu_pc    = res_q.pc;
    assign agu_load  = res_q.load;
    assign agu_byte  = res_q.byte_acc;
    assign agu_rd    = res_q.rd;
    assign agu_rob   = res_q.rob;

endmodule

// File: tb/tb_mem_agu_rs.sv
// tb/tb_mem_agu_rs.sv - self-checking bench for mem_agu_rs: vector table, corner sequences, random vs model
module tb_mem_agu_rs;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [11:0] alloc_pc;
    logic        alloc_load;
    logic        alloc_byte;
    logic [5:0]  alloc_s1_tag;
    logic        alloc_s1_rdy;
    logic [31:0] alloc_s1_val;
    logic [5:0]  alloc_s2_tag;
    logic        alloc_s2_rdy;
    logic [31:0] alloc_s2_val;
    logic [11:0] alloc_imm;
    logic [5:0]  alloc_rd;
    logic [3:0]  alloc_rob;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        agu_valid;
    logic [31:0] agu_addr;
    logic [31:0] agu_data;
    logic [11:0] agu_pc;
    logic        agu_load;
    logic        agu_byte;
    logic [5:0]  agu_rd;
    logic [3:0]  agu_rob;

    always #5 clk = ~clk;

    mem_agu_rs dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .alloc_valid  (alloc_valid),
        .alloc_ready  (alloc_ready),
        .alloc_pc     (alloc_pc),
        .alloc_load   (alloc_load),
        .alloc_byte   (alloc_byte),
        .alloc_s1_tag (alloc_s1_tag),
        .alloc_s1_rdy (alloc_s1_rdy),
        .alloc_s1_val (alloc_s1_val),
        .alloc_s2_tag (alloc_s2_tag),
        .alloc_s2_rdy (alloc_s2_rdy),
        .alloc_s2_val (alloc_s2_val),
        .alloc_imm    (alloc_imm),
        .alloc_rd     (alloc_rd),
        .alloc_rob    (alloc_rob),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .agu_valid    (agu_valid),
        .agu_addr     (agu_addr),
        .agu_data     (agu_data),
        .agu_pc       (agu_pc),
        .agu_load     (agu_load),
        .agu_byte     (agu_byte),
        .agu_rd       (agu_rd),
        .agu_rob      (agu_rob)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: one record per slot, ages as plain integers
    bit          m_v   [8];
    bit          m_ld  [8];
    bit          m_by  [8];
    logic [11:0] m_pc  [8];
    logic [5:0]  m_t1  [8];
    bit          m_r1  [8];
    logic [31:0] m_v1  [8];
    logic [5:0]  m_t2  [8];
    bit          m_r2  [8];
    logic [31:0] m_v2  [8];
    logic [11:0] m_imm [8];
    logic [5:0]  m_rd  [8];
    logic [3:0]  m_rob [8];
    int          m_age [8];

    bit          e_valid;
    logic [31:0] e_addr, e_data;
    logic [11:0] e_pc;
    bit          e_load, e_byte;
    logic [5:0]  e_rd;
    logic [3:0]  e_rob;
    bit          m_acc;
    logic [11:0] pc_q [$];

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(m_v[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_v[i] = 0;
            m_age[i] = 0;
        end
        e_valid = 0; e_addr = 0; e_data = 0; e_pc = 0;
        e_load = 0; e_byte = 0; e_rd = 0; e_rob = 0;
    endtask

    task automatic model_step();
        int  fi, best, off;
        bit  rdy, hit;
        fi = -1;
        best = -1;
        m_acc = 0;
        rdy = m_count() < 8;
        for (int i = 0; i < 8; i++) begin
            if (!m_v[i] && fi < 0) fi = i;
            if (m_v[i] && m_r1[i] && (m_ld[i] || m_r2[i]))
                if (best < 0 || m_age[i] > m_age[best]) best = i;
        end
        if (flush) begin
            for (int i = 0; i < 8; i++) m_v[i] = 0;
            e_valid = 0;
            return;
        end
        e_valid = (best >= 0);
        if (best >= 0) begin
            off    = $signed(m_imm[best]);
            e_addr = m_v1[best] + 32'(off);
            e_data = m_ld[best] ? 32'd0 : m_v2[best];
            e_pc   = m_pc[best];
            e_load = m_ld[best];
            e_byte = m_by[best];
            e_rd   = m_rd[best];
            e_rob  = m_rob[best];
            m_v[best] = 0;
        end
        hit = cdb_valid && cdb_tag != 0;
        for (int i = 0; i < 8; i++) begin
            if (m_v[i] && hit && !m_r1[i] && m_t1[i] == cdb_tag) begin m_r1[i] = 1; m_v1[i] = cdb_data; end
            if (m_v[i] && hit && !m_r2[i] && m_t2[i] == cdb_tag) begin m_r2[i] = 1; m_v2[i] = cdb_data; end
        end
        if (alloc_valid && rdy) begin
            m_acc = 1;
            for (int i = 0; i < 8; i++)
                if (m_v[i] && m_age[i] < 7) m_age[i]++;
            m_v[fi] = 1; m_ld[fi] = alloc_load; m_by[fi] = alloc_byte; m_pc[fi] = alloc_pc;
            m_t1[fi] = alloc_s1_tag; m_r1[fi] = alloc_s1_rdy; m_v1[fi] = alloc_s1_val;
            m_t2[fi] = alloc_s2_tag; m_r2[fi] = alloc_s2_rdy; m_v2[fi] = alloc_s2_val;
            m_imm[fi] = alloc_imm; m_rd[fi] = alloc_rd; m_rob[fi] = alloc_rob; m_age[fi] = 0;
            if (hit && !alloc_s1_rdy && alloc_s1_tag == cdb_tag) begin m_r1[fi] = 1; m_v1[fi] = cdb_data; end
            if (hit && !alloc_s2_rdy && alloc_s2_tag == cdb_tag) begin m_r2[fi] = 1; m_v2[fi] = cdb_data; end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("agu_out",
            128'({agu_valid, agu_addr, agu_data, agu_pc, agu_load, agu_byte, agu_rd, agu_rob}),
            128'({e_valid, e_addr, e_data, e_pc, e_load, e_byte, e_rd, e_rob}));
        chk("alloc_ready", 128'(alloc_ready), 128'(m_count() < 8));
        if (agu_valid) pc_q.push_back(agu_pc);
    endtask

    task automatic idle();
        alloc_valid = 0;
        cdb_valid   = 0;
        flush       = 0;
    endtask

    task automatic disp(input bit ld, input logic [11:0] pc, input logic [5:0] t1, input bit r1,
                        input logic [31:0] v1, input logic [5:0] t2, input bit r2,
                        input logic [31:0] v2, input logic [11:0] imm);
        alloc_valid = 1; alloc_load = ld; alloc_pc = pc; alloc_byte = pc[0];
        alloc_s1_tag = t1; alloc_s1_rdy = r1; alloc_s1_val = v1;
        alloc_s2_tag = t2; alloc_s2_rdy = r2; alloc_s2_val = v2;
        alloc_imm = imm; alloc_rd = pc[5:0]; alloc_rob = pc[3:0];
    endtask

    task automatic cdb(input logic [5:0] t, input logic [31:0] d);
        cdb_valid = 1; cdb_tag = t; cdb_data = d;
    endtask

    typedef struct {
        bit          fl, av, ld;
        logic [5:0]  t1;
        bit          r1;
        logic [31:0] v1;
        logic [5:0]  t2;
        bit          r2;
        logic [31:0] v2;
        logic [11:0] imm;
        bit          cv;
        logic [5:0]  ct;
        logic [31:0] cd;
        bit          ev;
        logic [31:0] ea, ed;
    } vec_t;

    vec_t        tbl [17];
    logic [11:0] exp_order [$];
    int          acc_c, first_c;

    initial begin
        //            fl av ld t1 r1 v1              t2 r2 v2 imm       cv ct cd            ev ea              ed
        tbl[0]  = '{0, 1, 1, 0, 1, 32'h100,       0, 0, 0, 12'hFFC, 0, 0, 0,            0, 0,              0};
        tbl[1]  = '{0, 0, 0, 0, 0, 0,             0, 0, 0, 0,       0, 0, 0,            1, 32'hFC,         0};
        tbl[2]  = '{0, 0, 0, 0, 0, 0,             0, 0, 0, 0,       0, 0, 0,            0, 0,              0};
        tbl[3]  = '{0, 1, 0, 0, 1, 32'h40,        5, 0, 0, 12'h010, 0, 0, 0,            0, 0,              0};
        tbl[4]  = '{0, 0, 0, 0, 0, 0,             0, 0, 0, 0,       0, 0, 0,            0, 0,              0};
        tbl[5]  = '{0, 0, 0, 0, 0, 0,             0, 0, 0, 0,       1, 5, 32'hDEAD,     0, 0,              0};
        tbl[6]  = '{0, 0, 0, 0, 0, 0,             0, 0, 0, 0,       0, 0, 0,            1, 32'h50,         32'hDEAD};
        tbl[7]  = '{0, 1, 1, 7, 0, 0,             0, 0, 0, 12'h004, 1, 7, 32'h200,      0, 0,              0};
        tbl[8]  = '{0, 0, 0, 0, 0, 0,             0, 0, 0, 0,       0, 0, 0,            1, 32'h204,        0};
        tbl[9]  = '{0, 0, 0, 0, 0, 0,             0, 0, 0, 0,       0, 0, 0,            0, 0,              0};
        tbl[10] = '{0, 1, 1, 0, 1, 32'h2,         0, 0, 0, 12'h800, 0, 0, 0,            0, 0,              0};
        tbl[11] = '{0, 0, 0, 0, 0, 0,             0, 0, 0, 0,       0, 0, 0,            1, 32'hFFFFF802,   0};
        tbl[12] = '{0, 0, 0, 0, 0, 0,             0, 0, 0, 0,       0, 0, 0,            0, 0,              0};
        tbl[13] = '{0, 1, 1, 0, 0, 0,             0, 0, 0, 0,       1, 0, 32'h55,       0, 0,              0};
        tbl[14] = '{0, 0, 0, 0, 0, 0,             0, 0, 0, 0,       0, 0, 0,            0, 0,              0};
        tbl[15] = '{0, 0, 0, 0, 0, 0,             0, 0, 0, 0,       0, 0, 0,            0, 0,              0};
        tbl[16] = '{1, 0, 0, 0, 0, 0,             0, 0, 0, 0,       0, 0, 0,            0, 0,              0};

        rst = 1;
        idle();
        disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
        alloc_valid = 0;
        cdb_tag = 0; cdb_data = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", 128'({agu_valid, agu_addr, agu_data, agu_pc, agu_load, agu_byte, agu_rd, agu_rob}), 128'(0));
        rst = 0;
        #1;
        chk("reset_ready", 128'(alloc_ready), 128'(1));

        // Directed vector table: ready load, waiting store, alloc bypass, negative offset, tag 0
        for (int i = 0; i < 17; i++) begin
            flush = tbl[i].fl;
            if (tbl[i].av)
                disp(tbl[i].ld, 12'(i + 1), tbl[i].t1, tbl[i].r1, tbl[i].v1,
                     tbl[i].t2, tbl[i].r2, tbl[i].v2, tbl[i].imm);
            else
                alloc_valid = 0;
            cdb_valid = tbl[i].cv; cdb_tag = tbl[i].ct; cdb_data = tbl[i].cd;
            tick();
            chk($sformatf("vec%0d_valid", i), 128'(agu_valid), 128'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d_addr", i), 128'(agu_addr), 128'(tbl[i].ea));
                chk($sformatf("vec%0d_data", i), 128'(agu_data), 128'(tbl[i].ed));
            end
        end
        idle();

        // Age order: C then A then B; two same-tag waiters issue oldest first
        pc_q.delete();
        disp(1, 12'hA1, 1, 0, 0, 0, 0, 0, 12'h001); tick();
        disp(1, 12'hB2, 2, 0, 0, 0, 0, 0, 12'h002); tick();
        disp(1, 12'hC3, 3, 0, 0, 0, 0, 0, 12'h003); tick();
        idle(); cdb(3, 32'h300); tick();
        idle(); tick();
        cdb(1, 32'h100); tick();
        idle(); tick();
        cdb(2, 32'h200); tick();
        idle(); tick(); tick();
        disp(1, 12'hD1, 4, 0, 0, 0, 0, 0, 12'h010); tick();
        disp(1, 12'hD2, 4, 0, 0, 0, 0, 0, 12'h020); tick();
        idle(); cdb(4, 32'h400); tick();
        idle(); repeat (4) tick();
        exp_order = '{12'hC3, 12'hA1, 12'hB2, 12'hD1, 12'hD2};
        chk("order_count", 128'(pc_q.size()), 128'(exp_order.size()));
        for (int k = 0; k < exp_order.size() && k < pc_q.size(); k++)
            chk($sformatf("order_%0d", k), 128'(pc_q[k]), 128'(exp_order[k]));

        // Full: 8 blocked entries, held 9th dispatch accepted the cycle after the first issue
        pc_q.delete();
        for (int i = 0; i < 8; i++) begin
            disp(1, 12'(12'h10 + i), 9, 0, 0, 0, 0, 0, 12'(i * 4));
            tick();
        end
        idle();
        chk("full_ready", 128'(alloc_ready), 128'(0));
        disp(1, 12'h20, 0, 1, 32'h1000, 0, 0, 0, 12'h008);
        cdb(9, 32'h900);
        acc_c = -1;
        first_c = -1;
        for (int c = 0; c < 16; c++) begin
            if (alloc_valid && alloc_ready && acc_c < 0) acc_c = c;
            tick();
            if (agu_valid && first_c < 0) first_c = c;
            if (acc_c >= 0) alloc_valid = 0;
            cdb_valid = 0;
        end
        idle();
        chk("full_first_issue", 128'(first_c), 128'(1));
        chk("full_held_accept", 128'(acc_c), 128'(2));
        exp_order = '{12'h10, 12'h11, 12'h12, 12'h13, 12'h14, 12'h15, 12'h16, 12'h17, 12'h20};
        chk("full_count", 128'(pc_q.size()), 128'(exp_order.size()));
        for (int k = 0; k < exp_order.size() && k < pc_q.size(); k++)
            chk($sformatf("full_order_%0d", k), 128'(pc_q[k]), 128'(exp_order[k]));

        // Flush with pending entries and a concurrent alloc
        for (int i = 0; i < 3; i++) begin
            disp(1, 12'(12'h31 + i), 11, 0, 0, 0, 0, 0, 0);
            tick();
        end
        pc_q.delete();
        disp(1, 12'h34, 0, 1, 32'h80, 0, 0, 0, 0);
        cdb(11, 32'hB00);
        flush = 1;
        tick();
        idle(); cdb(11, 32'hB01); tick();
        idle(); repeat (3) tick();
        chk("flush_no_issue", 128'(pc_q.size()), 128'(0));
        chk("flush_ready", 128'(alloc_ready), 128'(1));

        // Asynchronous reset with an output pulse and a pending eligible entry
        disp(1, 12'h41, 0, 1, 32'h1234, 0, 0, 0, 12'h008); tick();
        disp(0, 12'h42, 0, 1, 32'h2000, 0, 1, 32'h77, 12'h004); tick();
        idle();
        chk("pre_reset_valid", 128'(agu_valid), 128'(1));
        #3;
        rst = 1;
        #1;
        chk("async_reset_out", 128'({agu_valid, agu_addr, agu_data, agu_pc, agu_load, agu_byte, agu_rd, agu_rob}), 128'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
        pc_q.delete();
        repeat (3) tick();
        chk("reset_no_pending", 128'(pc_q.size()), 128'(0));

        // Randomised traffic against the model
        for (int c = 0; c < 800; c++) begin
            flush = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 1) == 1)
                disp($urandom_range(0, 1) == 1, 12'($urandom), 6'($urandom_range(0, 7)), $urandom_range(0, 2) == 0,
                     $urandom, 6'($urandom_range(0, 7)), $urandom_range(0, 2) == 0, $urandom, 12'($urandom));
            else
                alloc_valid = 0;
            cdb_valid = ($urandom_range(0, 1) == 1);
            cdb_tag   = 6'($urandom_range(0, 7));
            cdb_data  = $urandom;
            tick();
        end
        idle();
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
